// File: rtl/bit_fir_pkg.sv
// Shared types and helpers for the 1-bit FIR path (bit_tap_window,
// count_ones, downstream accumulator).
package bit_fir_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        RUN
    } tap_state_t;

    // Counter width that never collapses to zero bits (MOD of 1 or 2 -> 1 bit).
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter. wrap flags that the next inc returns count to 0,
// so a caller can act on the same cycle as the wrapping increment.
module mod_counter
    import bit_fir_pkg::*;
#(
    parameter int MOD = 4,
    parameter int W   = clog2_min1(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = (count == W'(MOD - 1));

    // Count increments, wrapping to zero after MOD-1; clr wins over inc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/bit_tap_window.sv
// N-tap shift window over a 1-bit stream, masked by a coefficient vector
// and emitted every DECIM accepted samples once the window is full.
// Optional macro BIT_TAP_WINDOW_DROP_EN: free-running input, outputs that
// collide with an unaccepted held output are dropped and flagged on overrun.
module bit_tap_window
    import bit_fir_pkg::*;
#(
    parameter int           N          = 8,
    parameter int           DECIM      = 4,
    parameter logic [N-1:0] COEFF_INIT = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bit,
    input  logic [N-1:0] coeff,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
`ifdef BIT_TAP_WINDOW_DROP_EN
    output logic         overrun,
`endif
    output logic         window_full
);

    localparam int FW = $clog2(N + 1);
    localparam int DW = clog2_min1(DECIM);

    tap_state_t      state, state_next;
    logic [N-1:0]    window, window_next, coeff_q;
    logic [FW-1:0]   fill_cnt;
    logic [DW-1:0]   decim_cnt;
    logic            decim_wrap;
    logic            accept, produce, load, fill_last;
    logic            decim_unused;

`ifdef BIT_TAP_WINDOW_DROP_EN
    // Input never stalls; a produced output only lands if the slot is free.
    assign in_ready = !flush;
    assign load     = produce && (!out_valid || out_ready);
`else
    // Input stalls while a held output is not being taken.
    assign in_ready = !flush && (!out_valid || out_ready);
    assign load     = produce;
`endif

    assign accept       = in_valid && in_ready;
    assign window_next  = {window[N-2:0], in_bit};
    assign fill_last    = (fill_cnt == FW'(N - 1));
    assign decim_unused = ^decim_cnt;

    // Decimation phase only advances once the window is full.
    mod_counter #(.MOD(DECIM), .W(DW)) u_decim (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .inc   (accept && (state == RUN)),
        .count (decim_cnt),
        .wrap  (decim_wrap)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    // Next state and output-produce decision.
    always_comb begin
        state_next = state;
        produce    = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else if (accept) begin
            case (state)
                EMPTY, FILL: begin
                    if (fill_last) begin
                        state_next = RUN;
                        produce    = 1'b1;
                    end else begin
                        state_next = FILL;
                    end
                end
                RUN:     produce = decim_wrap;
                default: state_next = EMPTY;
            endcase
        end
    end

    // Shift window, saturating fill count, coefficient capture on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window   <= '0;
            fill_cnt <= '0;
            coeff_q  <= COEFF_INIT;
        end else if (flush) begin
            window   <= '0;
            fill_cnt <= '0;
            coeff_q  <= coeff;
        end else if (accept) begin
            window <= window_next;
            if (fill_cnt != FW'(N)) fill_cnt <= fill_cnt + 1'b1;
        end
    end

    // window_full mirrors being in RUN, registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) window_full <= 1'b0;
        else     window_full <= (state_next == RUN);
    end

    // Output register: load masked window, hold until handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= window_next & coeff_q;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef BIT_TAP_WINDOW_DROP_EN
    // Sticky flag for outputs discarded because the held one was not taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   overrun <= 1'b0;
        else if (flush)            overrun <= 1'b0;
        else if (produce && !load) overrun <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_bit_tap_window.sv
// Directed bench for bit_tap_window (N=8, DECIM=4). Expected outputs are
// queued when the producing sample is driven and compared on handshake.
// With BIT_TAP_WINDOW_DROP_EN defined, the overrun path is also exercised.
module tb_bit_tap_window;

    localparam int N     = 8;
    localparam int DECIM = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_bit;
    logic [N-1:0] coeff;
    logic         flush;
    logic         out_valid, out_ready;
    logic [N-1:0] out_data;
    logic         window_full;
`ifdef BIT_TAP_WINDOW_DROP_EN
    logic         overrun;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0] sb[$];
    logic [N-1:0] m_win, m_coeff;
    int           m_cnt;

    bit_tap_window #(.N(N), .DECIM(DECIM)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bit      (in_bit),
        .coeff       (coeff),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
`ifdef BIT_TAP_WINDOW_DROP_EN
        .overrun     (overrun),
`endif
        .window_full (window_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: output after the Nth accept, then every DECIM accepts.
    task automatic model_accept(input logic b);
        m_win = {m_win[N-2:0], b};
        m_cnt++;
        if (m_cnt == N || (m_cnt > N && (m_cnt - N) % DECIM == 0))
            sb.push_back(m_win & m_coeff);
    endtask

    task automatic model_clear(input logic [N-1:0] c);
        m_win   = '0;
        m_cnt   = 0;
        m_coeff = c;
        sb.delete();
    endtask

    // Called just after a rising edge; returns 1 time unit after the accept edge.
    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        #1;
        for (int k = 0; k < 20 && in_ready !== 1'b1; k++) begin
            @(posedge clk); #2;
        end
        check("in_ready", in_ready, 1);
        model_accept(b);
        @(posedge clk); #1;
    endtask

    task automatic do_flush(input logic [N-1:0] c);
        in_valid = 1'b0;
        flush    = 1'b1;
        coeff    = c;
        model_clear(c);
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    // Scoreboard consumer: compare on every handshake.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) check("sb_unexpected", {24'h0, out_data}, 32'hFFFF_FFFF);
            else                check("sb_data", out_data, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; coeff = 8'hFF;
        flush = 1'b0; out_ready = 1'b1;
        model_clear(8'hFF);

        // 1. reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_window_full", window_full, 0);
`ifdef BIT_TAP_WINDOW_DROP_EN
        check("rst_overrun", overrun, 0);
`endif

        // 2. fill: 1,0,1,1,0,0,1,0 -> B2 one cycle after the 8th accept
        pat = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            send_bit(pat[7-i]);
            if (i == 6) begin
                check("fill7_window_full", window_full, 0);
                check("fill7_out_valid", out_valid, 0);
            end
        end
        check("fill8_out_valid", out_valid, 1);
        check("fill8_out_data", out_data, 8'hB2);
        check("fill8_window_full", window_full, 1);

        // 3. decimation: 1,1,1,1 -> nothing for 9..11, 2F after 12
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1);
            check("decim_gap_out_valid", out_valid, 0);
        end
        send_bit(1'b1);
        check("decim12_out_valid", out_valid, 1);
        check("decim12_out_data", out_data, 8'h2F);

        // 4. backpressure: hold 2F for 5 cycles
        out_ready = 1'b0;
        in_bit    = 1'b0;
`ifdef BIT_TAP_WINDOW_DROP_EN
        in_valid  = 1'b0;
`endif
        repeat (5) begin
            #1;
`ifndef BIT_TAP_WINDOW_DROP_EN
            check("bp_in_ready", in_ready, 0);
`endif
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, 8'h2F);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        // window must not have shifted during the stall
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_next_out_data", out_data, 8'hF3);

        // flush discards a held output
        do_flush(8'hFF);
        check("flush_drop_out_valid", out_valid, 0);
        check("flush_drop_out_data", out_data, 0);
        check("flush_drop_window_full", window_full, 0);
        out_ready = 1'b1;

        // 5. five samples, flush with 0F, then eight ones
        pat = 8'b1010_1000;
        for (int i = 0; i < 5; i++) send_bit(pat[7-i]);
        do_flush(8'h0F);
        check("flush_window_full", window_full, 0);
        check("flush_out_valid", out_valid, 0);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1);
            if (i == 6) check("refill7_out_valid", out_valid, 0);
        end
        check("refill8_out_valid", out_valid, 1);
        check("refill8_out_data", out_data, 8'h0F);

        // 6. async reset between edges while out_valid is high
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_window_full", window_full, 0);
        check("arst_out_data", out_data, 0);
        #1 rst = 1'b0;
        model_clear(8'hFF);
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1);
            if (i == 6) check("arst_refill7_out_valid", out_valid, 0);
        end
        check("arst_refill8_out_valid", out_valid, 1);
        check("arst_refill8_out_data", out_data, 8'hFF);

`ifdef BIT_TAP_WINDOW_DROP_EN
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(i[0]);
        in_valid = 1'b0;
        check("drop_overrun", overrun, 1);
        check("drop_out_valid", out_valid, 1);
        check("drop_out_data", out_data, 8'hFF);
        sb.delete();
        sb.push_back(8'hFF);
        out_ready = 1'b1;
`endif

        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
